// File: rtl/mem_bus_master_pkg.sv
// Shared types for the CPU-side memory bus master.
//   cpu_mem_bus_t : request bus driven toward the memory controller
//   mbm_state_t   : master FSM state encoding
//   mbm_op_t      : kind of transaction currently in flight
//   MEM_LAT       : default controller read latency in cycles
package types;

    localparam int MEM_LAT = 2;
    localparam int AW      = 16;
    localparam int DW      = 16;

    typedef struct packed {
        logic          addr_valid;
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] data2mem;
        logic          ptr_valid;
        logic [31:0]   ptr;
    } cpu_mem_bus_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH0,
        FETCH1,
        DATA,
        WAIT,
        RESP
    } mbm_state_t;

    typedef enum logic [1:0] {
        OP_LOAD,
        OP_STORE,
        OP_FETCH
    } mbm_op_t;

    // Pointer-port request for a two-word fetch: {addr+1, addr}.
    // The sum is self-determined at 16 bits, so 0xFFFF wraps to 0x0000.
    function automatic logic [31:0] fetch_ptr(input logic [AW-1:0] a);
        return {a + 16'd1, a};
    endfunction

endpackage

// File: rtl/mem_bus_master_lat_counter.sv
// mbm_lat_counter: read-latency timer shared by the load and fetch paths.
//   clk, rst_n : clock, async active-low reset
//   start      : pulse in the first bus-drive cycle of a read
//   done       : high in the cycle whose closing edge is LAT edges after
//                the start cycle began, i.e. the data capture cycle
import types::*;

module mbm_lat_counter #(
    parameter int LAT = MEM_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    localparam int            CW     = $clog2(LAT + 1);
    localparam logic [CW-1:0] RELOAD = CW'(LAT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // With LAT=1 the capture edge closes the start cycle itself; otherwise
    // the count reaches 1 in the last cycle before capture and then parks at 0.
    assign done = start ? (LAT == 1) : (cnt == CW'(1));

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: arbitrates CPU fetch and load/store requests onto the
// memory controller request bus, one transaction at a time.
//   clk, rst_n                 : clock, async active-low reset
//   if_req/if_addr             : fetch request (held until if_ready)
//   if_ready/if_valid/if_data  : accept pulse, data pulse, {mem[a+1], mem[a]}
//   ls_req/ls_we/ls_addr/ls_wdata : load/store request (held until ls_ready)
//   ls_ready/ls_valid/ls_rdata : accept pulse, completion pulse, load data
//   bus                        : request bus to the controller
//   cpu_out/instr_out          : data-port / pointer-port read returns
//   busy                       : FSM not in IDLE
import types::*;

module mem_bus_master #(
    parameter int LAT = MEM_LAT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic          if_valid,
    output logic [31:0]   if_data,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_ready,
    output logic          ls_valid,
    output logic [DW-1:0] ls_rdata,
    output cpu_mem_bus_t  bus,
    input  logic [DW-1:0] cpu_out,
    input  logic [DW-1:0] instr_out,
    output logic          busy
);

    mbm_state_t    state, state_n;
    mbm_op_t       op;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          grab1;       // word0 was captured last cycle; word1 is due now
    logic          cnt_start, cnt_done;
    logic          cap_ld, cap_w0, cap_w1;

    mbm_lat_counter #(.LAT(LAT)) u_lat (
        .clk   (clk),
        .rst_n (rst_n),
        .start (cnt_start),
        .done  (cnt_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        bus       = '0;
        if_ready  = 1'b0;
        ls_ready  = 1'b0;
        if_valid  = 1'b0;
        ls_valid  = 1'b0;
        cnt_start = 1'b0;
        cap_ld    = 1'b0;
        cap_w0    = 1'b0;
        cap_w1    = 1'b0;
        case (state)
            IDLE: begin
                // Ready is combinational and gated by rst_n so a request
                // held through reset is not acknowledged.
                if (rst_n && ls_req) begin
                    ls_ready = 1'b1;
                    state_n  = DATA;
                end else if (rst_n && if_req) begin
                    if_ready = 1'b1;
                    state_n  = FETCH0;
                end
            end
            DATA: begin
                bus.addr_valid = 1'b1;
                bus.addr       = r_addr;
                bus.write      = (op == OP_STORE);
                bus.data2mem   = r_wdata;
                if (op == OP_STORE) begin
                    state_n = RESP;
                end else begin
                    cnt_start = 1'b1;
                    if (cnt_done) begin
                        cap_ld  = 1'b1;
                        state_n = RESP;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            FETCH0: begin
                bus.ptr_valid = 1'b1;
                bus.ptr       = fetch_ptr(r_addr);
                cnt_start     = 1'b1;
                cap_w0        = cnt_done;
                state_n       = FETCH1;
            end
            FETCH1: begin
                bus.ptr_valid = 1'b1;
                bus.ptr       = fetch_ptr(r_addr);
                if (grab1) begin
                    cap_w1  = 1'b1;
                    state_n = RESP;
                end else begin
                    cap_w0  = cnt_done;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (op == OP_FETCH) begin
                    if (grab1) begin
                        cap_w1  = 1'b1;
                        state_n = RESP;
                    end else begin
                        cap_w0 = cnt_done;
                    end
                end else if (cnt_done) begin
                    cap_ld  = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                if (op == OP_FETCH) begin
                    if_valid = 1'b1;
                end else begin
                    ls_valid = 1'b1;
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op       <= OP_LOAD;
            r_addr   <= '0;
            r_wdata  <= '0;
            grab1    <= 1'b0;
            if_data  <= '0;
            ls_rdata <= '0;
        end else begin
            if (ls_ready) begin
                op      <= ls_we ? OP_STORE : OP_LOAD;
                r_addr  <= ls_addr;
                r_wdata <= ls_wdata;
            end else if (if_ready) begin
                op     <= OP_FETCH;
                r_addr <= if_addr;
            end
            grab1 <= cap_w0;
            if (cap_w0) if_data[15:0]  <= instr_out;
            if (cap_w1) if_data[31:16] <= instr_out;
            if (cap_ld) ls_rdata       <= cpu_out;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_master.sv
import types::*;

module tb_mem_bus_master;

    localparam int LAT = 2;   // memory model below has one register stage

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, ls_req, ls_we;
    logic [15:0]   if_addr, ls_addr, ls_wdata;
    logic          if_ready, if_valid, ls_ready, ls_valid, busy;
    logic [31:0]   if_data;
    logic [15:0]   ls_rdata;
    cpu_mem_bus_t  bus;
    logic [15:0]   cpu_out, instr_out;

    mem_bus_master #(.LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_valid(if_valid), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ready(ls_ready), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
        .bus(bus), .cpu_out(cpu_out), .instr_out(instr_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: registered read on each port, unreset half toggle.
    logic [15:0] mem [0:65535];
    logic        half = 1'b0;
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[16'h0010] <= 16'hBEEF;
            mem[16'h0030] <= 16'hCAFE;
            mem[16'h0100] <= 16'h1111;
            mem[16'h0101] <= 16'h2222;
            mem[16'hFFFF] <= 16'hAAAA;
            mem[16'h0000] <= 16'h5555;
        end else begin
            if (bus.addr_valid && bus.write)  mem[bus.addr] <= bus.data2mem;
            if (bus.addr_valid && !bus.write) cpu_out <= mem[bus.addr];
            if (bus.ptr_valid) begin
                instr_out <= half ? mem[bus.ptr[31:16]] : mem[bus.ptr[15:0]];
                half      <= ~half;
            end
        end
    end

    typedef struct {
        int          kind;    // 0 load, 1 store, 2 fetch
        logic [31:0] data;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [31:0] ptr;
        int          lat;
    } exp_t;

    exp_t ls_q[$];
    exp_t if_q[$];
    int   tests = 0;
    int   fails = 0;
    int   viol  = 0;
    logic [15:0] last_rd = 16'h0;
    int   last_ls_valid_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: protocol checks each cycle, scoreboard pop on valid pulses.
    initial begin : monitor
        int          acc_cyc, n_addr, n_ptr;
        logic [15:0] c_addr, c_wdata;
        logic        c_write;
        logic [31:0] c_ptr;
        exp_t        e;
        acc_cyc = 0; n_addr = 0; n_ptr = 0;
        c_addr = '0; c_wdata = '0; c_write = 1'b0; c_ptr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                n_addr = 0;
                n_ptr  = 0;
            end else begin
                if (bus.addr_valid && bus.ptr_valid) viol++;
                if (bus.write && !bus.addr_valid)    viol++;
                if (!busy && bus !== '0)             viol++;
                if (ls_ready || if_ready) begin
                    acc_cyc = cyc; n_addr = 0; n_ptr = 0;
                end
                if (bus.addr_valid) begin
                    n_addr++;
                    c_addr = bus.addr; c_write = bus.write; c_wdata = bus.data2mem;
                end
                if (bus.ptr_valid) begin
                    if (n_ptr == 0) c_ptr = bus.ptr;
                    n_ptr++;
                end
                if (ls_valid) begin
                    last_ls_valid_cyc = cyc;
                    if (ls_q.size() == 0) begin
                        check("ls_unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        e = ls_q.pop_front();
                        check("ls_latency", cyc - acc_cyc, e.lat);
                        check("ls_rdata", {16'h0, ls_rdata}, e.data);
                        check("ls_addr_cycles", n_addr, 1);
                        check("ls_ptr_cycles", n_ptr, 0);
                        check("ls_bus_addr", {16'h0, c_addr}, {16'h0, e.addr});
                        check("ls_bus_write", {31'h0, c_write}, (e.kind == 1) ? 32'd1 : 32'd0);
                        if (e.kind == 1) check("ls_data2mem", {16'h0, c_wdata}, {16'h0, e.wdata});
                    end
                end
                if (if_valid) begin
                    if (if_q.size() == 0) begin
                        check("if_unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        e = if_q.pop_front();
                        check("if_latency", cyc - acc_cyc, e.lat);
                        check("if_data", if_data, e.data);
                        check("if_ptr", c_ptr, e.ptr);
                        check("if_ptr_cycles", n_ptr, 2);
                        check("if_addr_cycles", n_addr, 0);
                    end
                end
            end
        end
    end

    task automatic issue_ls(input logic we, input logic [15:0] a, input logic [15:0] wd,
                            input logic [15:0] exp_d, output int acc);
        exp_t e;
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = wd;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ls_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            check("ls_ready_timeout", 32'd1, 32'd0);
        end else begin
            e.kind = we ? 1 : 0; e.data = {16'h0, exp_d}; e.addr = a;
            e.wdata = wd; e.ptr = '0; e.lat = we ? 2 : LAT + 1;
            ls_q.push_back(e);
        end
        @(posedge clk); #1;
        ls_req = 1'b0; ls_we = 1'b0;
    endtask

    task automatic issue_if(input logic [15:0] a, input logic [31:0] exp_d,
                            input logic [31:0] exp_p, output int acc);
        exp_t e;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = a;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            check("if_ready_timeout", 32'd1, 32'd0);
        end else begin
            e.kind = 2; e.data = exp_d; e.addr = a; e.wdata = '0;
            e.ptr = exp_p; e.lat = LAT + 2;
            if_q.push_back(e);
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic wait_done();
        int ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && ls_q.size() == 0 && if_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     {31'h0, busy}, 32'd0);
        check({tag, "_bus_zero"}, {31'h0, (bus !== '0)}, 32'd0);
        check({tag, "_if_ready"}, {31'h0, if_ready}, 32'd0);
        check({tag, "_ls_ready"}, {31'h0, ls_ready}, 32'd0);
        check({tag, "_if_valid"}, {31'h0, if_valid}, 32'd0);
        check({tag, "_ls_valid"}, {31'h0, ls_valid}, 32'd0);
        check({tag, "_if_data"},  if_data, 32'h0);
        check({tag, "_ls_rdata"}, {16'h0, ls_rdata}, 32'h0);
    endtask

    initial begin : stim
        int a1, a2, got;
        rst_n = 1'b0;
        if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        if_req = 1'b0; ls_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // load, store, reload of stored word
        issue_ls(1'b0, 16'h0010, 16'h0000, 16'hBEEF, a1); last_rd = 16'hBEEF;
        wait_done();
        issue_ls(1'b1, 16'h0020, 16'h1234, last_rd, a1);
        wait_done();
        issue_ls(1'b0, 16'h0020, 16'h0000, 16'h1234, a1); last_rd = 16'h1234;
        wait_done();

        // fetches, including the 16-bit wrap
        issue_if(16'hFFFF, 32'h5555AAAA, 32'h0000FFFF, a1);
        wait_done();
        issue_if(16'h0100, 32'h22221111, 32'h01010100, a1);
        wait_done();

        // simultaneous requests: load first, fetch right after its valid
        fork
            issue_ls(1'b0, 16'h0030, 16'h0000, 16'hCAFE, a1);
            issue_if(16'h0100, 32'h22221111, 32'h01010100, a2);
        join
        last_rd = 16'hCAFE;
        wait_done();
        check("prio_ls_first", {31'h0, (a1 < a2)}, 32'd1);
        check("if_accept_after_ls_valid", a2, last_ls_valid_cyc + 1);

        // reset while a load sits in WAIT
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0010;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ls_ready) begin
                got = 1;
                break;
            end
        end
        check("rst_test_accept", got, 1);
        @(posedge clk); #1;
        ls_req = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_busy", {31'h0, busy}, 32'd1);
        rst_n = 1'b0; ls_req = 1'b1; if_req = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        ls_req = 1'b0; if_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        last_rd = 16'h0;

        issue_ls(1'b0, 16'h0010, 16'h0000, 16'hBEEF, a1); last_rd = 16'hBEEF;
        wait_done();
        issue_if(16'hFFFF, 32'h5555AAAA, 32'h0000FFFF, a1);
        wait_done();

        check("bus_protocol_violations", viol, 0);
        check("ls_queue_empty", ls_q.size(), 0);
        check("if_queue_empty", if_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
